bus_regbank: RTL



---
 rtl/bus_regbank.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_regbank.sv
// -----------------------------------------------------------------------------
// bus_regbank
//   Register-bank slave on the 16-bit PS-to-PL local bus. The bank holds an ID
//   word, a write-to-pulse register, a write counter, NRW read/write control
//   registers and NRO read-only status registers, all at a base address ABASE.
//
//   Offset map (relative to ABASE):
//     0                 ID        (RO, returns ID_VALUE)
//     1                 PULSE     (WO, one-cycle pulse, reads 0)
//     2                 WRCOUNT   (RO, count of accepted writes; a write clears)
//     3 .. 2+NRW        CTRL[k]   (RW)
//     3+NRW .. 2+NRW+NRO STATUS[j] (RO, sampled from the status input)
//
//   Read data is registered and is zero whenever brdack is low, so several
//   banks can be OR-combined onto one brddata bus.
//
// Ports:
//   clk      bus/fabric clock (plclk)
//   reset    synchronous, active-high reset
//   baddr    bus address
//   bwrdata  bus write data
//   bwr      1 = write, 0 = read; qualified by bstrobe
//   bstrobe  one-cycle transaction strobe
//   brddata  registered read data; 0 when not acking
//   brdack   one-cycle read acknowledge, aligned with brddata
//   ctrl     RW registers; register k at [16k+15:16k]
//   status   RO inputs; word j at [16j+15:16j]; ignored when NRO = 0
//   pulse    one-cycle pulse outputs
// -----------------------------------------------------------------------------
module bus_regbank #(
  parameter logic [15:0] ABASE    = 16'h0000,
  parameter int          NRW      = 4,
  parameter int          NRO      = 2,
  parameter int          NPULSE   = 8,
  parameter logic [15:0] RW_INIT  = 16'h0000,
  parameter logic [15:0] ID_VALUE = 16'hA7D0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [15:0]                         baddr,
  input  logic [15:0]                         bwrdata,
  input  logic                                bwr,
  input  logic                                bstrobe,
  output logic [15:0]                         brddata,
  output logic                                brdack,
  output logic [NRW*16-1:0]                   ctrl,
  input  logic [((NRO > 0) ? NRO : 1)*16-1:0] status,
  output logic [NPULSE-1:0]                   pulse
);

  localparam int NTOT      = 3 + NRW + NRO;
  localparam int OFF_ID    = 0;
  localparam int OFF_PULSE = 1;
  localparam int OFF_WRCNT = 2;
  localparam int CTRL_BASE = 3;
  localparam int STAT_BASE = 3 + NRW;

  // State
  logic [NRW-1:0][15:0] ctrl_q, ctrl_d;
  logic [NPULSE-1:0]    pulse_q, pulse_d;
  logic [15:0]          wrcount_q, wrcount_d;
  logic                 rdack_q, rdack_d;
  logic [15:0]          rddata_q, rddata_d;

  // Address decode
  logic [16:0] off17;
  logic [31:0] off;
  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic [15:0] rd_mux;

  // The subtraction is done one bit wider than the bus so an address below
  // ABASE borrows into bit 16 instead of wrapping to a small offset near
  // 16'hFFFF.
  assign off17  = {1'b0, baddr} - {1'b0, ABASE};
  assign off    = 32'(off17);
  assign hit    = bstrobe && (baddr >= ABASE) && (off < NTOT);
  assign wr_hit = hit && bwr;
  assign rd_hit = hit && !bwr;

  // Read multiplexer: values as they stand at the strobe edge. Unmapped and
  // write-only offsets read as zero.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    rd_mux = 16'h0000;
    if (off == OFF_ID) begin
      rd_mux = ID_VALUE;
    end else if (off == OFF_WRCNT) begin
      rd_mux = wrcount_q;
    end
    for (int k = 0; k < NRW; k++) begin
      if (off == 32'(CTRL_BASE + k)) rd_mux = ctrl_q[k];
    end
    for (int j = 0; j < NRO; j++) begin
      if (off == 32'(STAT_BASE + j)) rd_mux = status[16*j +: 16];
    end
  end

  // Next-state logic
  always_comb begin
    ctrl_d    = ctrl_q;
    pulse_d   = '0;          // pulse is high only in the cycle after its write
    wrcount_d = wrcount_q;
    if (wr_hit) begin
      // Clearing WRCOUNT takes priority over counting that same write.
      wrcount_d = (off == OFF_WRCNT) ? 16'h0000 : wrcount_q + 16'd1;
      if (off == OFF_PULSE) pulse_d = bwrdata[NPULSE-1:0];
      for (int k = 0; k < NRW; k++) begin
        if (off == 32'(CTRL_BASE + k)) ctrl_d[k] = bwrdata;
      end
    end
    rdack_d  = rd_hit;
    rddata_d = rd_hit ? rd_mux : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the control registers are reset like ordinary flops (not left
      // as uninitialised storage) because software expects RW_INIT after
      // reset; there are only NRW of them.
      ctrl_q    <= {NRW{RW_INIT}};
      pulse_q   <= '0;
      wrcount_q <= 16'h0000;
      rdack_q   <= 1'b0;
      rddata_q  <= 16'h0000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      ctrl_q    <= ctrl_d;
      pulse_q   <= pulse_d;
      wrcount_q <= wrcount_d;
      rdack_q   <= rdack_d;
      rddata_q  <= rddata_d;
    end
  end

  assign ctrl    = ctrl_q;
  assign pulse   = pulse_q;
  assign brdack  = rdack_q;
  assign brddata = rddata_q;

endmodule
